// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiply controller, datapath and collector.
package mm_pkg;

   localparam int unsigned MM_DW = 16;
   localparam int unsigned MM_N  = 9;
   localparam int unsigned MM_IW = 4;
   localparam int unsigned MM_CW = 8;

   // Index value the controller drives when no result is presented
   localparam logic [MM_IW-1:0] MM_IDX_IDLE = 4'b1011;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } mm_state_e;

endpackage

// File: rtl/mm_result_regfile.sv
// N-entry result store with per-entry valid bits; one write port, one read port.
module mm_result_regfile
   import mm_pkg::*;
#(
   parameter int unsigned DW = MM_DW,
   parameter int unsigned N  = MM_N,
   parameter int unsigned IW = MM_IW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [DW-1:0] wr_data,
   input  logic          pop,
   input  logic [IW-1:0] rd_idx,
   output logic [DW-1:0] rd_data,
   output logic          rd_vld,
   output logic [N-1:0]  vld
);

   logic [DW-1:0] mem [N];

   // Data storage; contents are don't-care until the valid bit is set
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N; i++) begin
         if (wr_en && wr_idx == IW'(i)) mem[i] <= wr_data;
      end
   end

   // Valid bits; a write to the entry being popped wins so it stays valid
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         vld <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (pop && rd_idx == IW'(i))   vld[i] <= 1'b0;
            if (wr_en && wr_idx == IW'(i)) vld[i] <= 1'b1;
         end
      end
   end

   // Read mux at the read pointer
   always_comb begin
      rd_data = '0;
      rd_vld  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (rd_idx == IW'(i)) begin
            rd_data = mem[i];
            rd_vld  = vld[i];
         end
      end
   end

endmodule

// File: rtl/mm_result_collector.sv
// Reorders indexed MAC results into a row-major valid/ready stream with frame status.
module mm_result_collector
   import mm_pkg::*;
#(
   parameter int unsigned DW = MM_DW,
   parameter int unsigned N  = MM_N,
   parameter int unsigned IW = MM_IW,
   parameter int unsigned CW = MM_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          output_set,
   input  logic          mem_clr,
   input  logic [IW-1:0] res_idx,
   input  logic [DW-1:0] res_data,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          dout_last,
   output logic          frame_done,
   output logic [CW-1:0] frame_cnt,
   output logic          busy,
   output logic          err_overrun
);

   mm_state_e     state;
   mm_state_e     state_nxt;
   logic [IW-1:0] rd_ptr;
   logic [N-1:0]  vld;
   logic [DW-1:0] rf_rd_data;
   logic          rf_rd_vld;

   logic          wr_req;
   logic          tgt_vld;
   logic          pop;
   logic          pop_same;
   logic          wr_acc;
   logic          overrun;
   logic          wrap;
   logic          ptr_last;

   mm_result_regfile #(
      .DW (DW),
      .N  (N),
      .IW (IW)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .clr     (mem_clr),
      .wr_en   (wr_acc),
      .wr_idx  (res_idx),
      .wr_data (res_data),
      .pop     (pop),
      .rd_idx  (rd_ptr),
      .rd_data (rf_rd_data),
      .rd_vld  (rf_rd_vld),
      .vld     (vld)
   );

   // Write/pop arbitration; mem_clr suppresses both
   always_comb begin
      wr_req   = output_set && (res_idx < IW'(N));
      tgt_vld  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (res_idx == IW'(i)) tgt_vld = vld[i];
      end
      ptr_last = (rd_ptr == IW'(N - 1));
      pop      = rf_rd_vld && dout_ready && !mem_clr;
      pop_same = pop && (rd_ptr == res_idx);
      wr_acc   = wr_req && !mem_clr && (!tgt_vld || pop_same);
      overrun  = wr_req && !mem_clr && tgt_vld && !pop_same;
      wrap     = pop && ptr_last;
   end

   assign dout       = rf_rd_data;
   assign dout_valid = rf_rd_vld;
   assign dout_last  = rf_rd_vld && ptr_last;
   assign busy       = (state == COLLECT);

   // Read pointer walks 0..N-1 on each transfer
   always_ff @(posedge clk) begin
      if (reset || mem_clr) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= wrap ? '0 : rd_ptr + IW'(1);
      end
   end

   // Frame completion pulse and wrapping frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= wrap;
         if (wrap) frame_cnt <= frame_cnt + CW'(1);
      end
   end

   // Sticky overrun flag, cleared only by reset or flush
   always_ff @(posedge clk) begin
      if (reset || mem_clr) begin
         err_overrun <= 1'b0;
      end else if (overrun) begin
         err_overrun <= 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state; leave COLLECT only once a frame ends with nothing pending
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (wr_acc) state_nxt = COLLECT;
         COLLECT: if (frame_done && vld == '0 && !wr_acc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (mem_clr) state_nxt = IDLE;
   end

endmodule
